// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-side stage behind the LC-3 bus mux.
// Holds MAR/MDR. Runs single-word SRAM reads and writes with a fixed
// WAIT_CYCLES strobe window. Pulses mem_rdy for one cycle when an access
// completes.
//
// Optional build macro MMIO_LED_EN maps address 16'hFFFF to I/O. A read
// returns {4'b0, SW} and a write updates LED. SRAM strobes stay inactive for
// these accesses, and the timing matches a normal access.
//
// Handshake: mem_rd_req / mem_wr_req are sampled only while IDLE (busy=0).
// A request seen on a rising edge is accepted on that edge and stays
// committed until completion. Completion is the single-cycle mem_rdy pulse.
// While busy, all requests and register loads are ignored.
module mem_access_unit #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       bus_in,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [15:0]       mem_rdata,
`ifdef MMIO_LED_EN
  input  logic [11:0]       SW,
  output logic [11:0]       LED,
`endif
  output logic [ADDR_W-1:0] MAR,
  output logic [15:0]       MDR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_rdy,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0]        LAST_CNT  = 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] MMIO_ADDR = ADDR_W'(16'hFFFF);

  state_t            state;
  state_t            next_state;
  logic [3:0]        cnt;
  logic [3:0]        cnt_d;
  logic [ADDR_W-1:0] mar_d;
  logic [15:0]       mdr_d;
  logic              last;
  logic              mmio_cur;
  logic              mmio_next;
  logic              ce_n_d;
  logic              oe_n_d;
  logic              we_n_d;
  logic              rdy_d;
  logic              busy_d;

  assign last      = (cnt == LAST_CNT);
  assign mem_addr  = MAR;
  assign mem_wdata = MDR;
  assign state_dbg = state;

`ifdef MMIO_LED_EN
  // MAR is frozen during an access, so the current MAR identifies an I/O access.
  assign mmio_cur  = (MAR == MMIO_ADDR);
  assign mmio_next = (mar_d == MMIO_ADDR);
`else
  assign mmio_cur  = 1'b0;
  assign mmio_next = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic: read wins over write, and the window ends on the last count.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (mem_rd_req)      next_state = S_RD;
        else if (mem_wr_req) next_state = S_WR;
      end
      S_RD:   if (last) next_state = S_DONE;
      S_WR:   if (last) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath next values. Loads apply only in IDLE; read data is captured on the last RD cycle.
  always_comb begin
    mar_d = MAR;
    mdr_d = MDR;
    cnt_d = 4'd0;
    unique case (state)
      S_IDLE: begin
        if (LD_MAR)            mar_d = ADDR_W'(bus_in);
        if (LD_MDR && !MIO_EN) mdr_d = bus_in;
      end
      S_RD: begin
        if (!last) begin
          cnt_d = cnt + 4'd1;
        end else begin
`ifdef MMIO_LED_EN
          mdr_d = mmio_cur ? {4'b0000, SW} : mem_rdata;
`else
          mdr_d = mem_rdata;
`endif
        end
      end
      S_WR: begin
        if (!last) cnt_d = cnt + 4'd1;
      end
      default: cnt_d = 4'd0;
    endcase
  end

  // Output decode from the next state so every strobe leaves a flop.
  always_comb begin
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    rdy_d  = (next_state == S_DONE);
    busy_d = (next_state != S_IDLE);
    if (next_state == S_RD && !mmio_next) begin
      ce_n_d = 1'b0;
      oe_n_d = 1'b0;
    end
    if (next_state == S_WR && !mmio_next) begin
      ce_n_d = 1'b0;
      we_n_d = 1'b0;
    end
  end

  // Registers for the datapath, counter and outputs; reset aborts any access.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      MAR      <= '0;
      MDR      <= 16'h0000;
      cnt      <= 4'd0;
      mem_ce_n <= 1'b1;
      mem_oe_n <= 1'b1;
      mem_we_n <= 1'b1;
      mem_rdy  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      MAR      <= mar_d;
      MDR      <= mdr_d;
      cnt      <= cnt_d;
      mem_ce_n <= ce_n_d;
      mem_oe_n <= oe_n_d;
      mem_we_n <= we_n_d;
      mem_rdy  <= rdy_d;
      busy     <= busy_d;
    end
  end

`ifdef MMIO_LED_EN
  // LED register: updated when an I/O write reaches the end of its window.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      LED <= 12'h000;
    end else if (state == S_WR && last && mmio_cur) begin
      LED <= MDR[11:0];
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Expected read data is pushed to a
// queue when a read is issued and is popped when mem_rdy is seen.
module tb_mem_access_unit;

  localparam int W = 2;

  logic        Clk;
  logic        Reset;
  logic [15:0] bus_in;
  logic        LD_MAR;
  logic        LD_MDR;
  logic        MIO_EN;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [15:0] mem_rdata;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic        mem_rdy;
  logic        busy;
  logic [1:0]  state_dbg;
`ifdef MMIO_LED_EN
  logic [11:0] SW;
  logic [11:0] LED;
`endif

  logic [15:0] exp_q[$];
  int          n_tests;
  int          n_fail;

  mem_access_unit #(.WAIT_CYCLES(W), .ADDR_W(16)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .bus_in     (bus_in),
    .LD_MAR     (LD_MAR),
    .LD_MDR     (LD_MDR),
    .MIO_EN     (MIO_EN),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_rdata  (mem_rdata),
`ifdef MMIO_LED_EN
    .SW         (SW),
    .LED        (LED),
`endif
    .MAR        (MAR),
    .MDR        (MDR),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ce_n   (mem_ce_n),
    .mem_oe_n   (mem_oe_n),
    .mem_we_n   (mem_we_n),
    .mem_rdy    (mem_rdy),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Clock: inputs change and outputs are sampled on the falling edge.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_mar(input logic [15:0] v);
    LD_MAR = 1'b1; bus_in = v;
    @(negedge Clk);
    LD_MAR = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] v, input logic mio);
    LD_MDR = 1'b1; MIO_EN = mio; bus_in = v;
    @(negedge Clk);
    LD_MDR = 1'b0; MIO_EN = 1'b0;
  endtask

  // Issue a request on the current falling edge, then watch the access until mem_rdy.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [15:0] exp_addr, input logic [15:0] exp_wdata,
                            input logic poke, input logic strobes_on);
    int   rdy_cyc;
    int   ce_cnt;
    int   oe_cnt;
    int   we_cnt;
    logic stable;
    logic [15:0] exp_d;
    rdy_cyc = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; stable = 1'b1;
    mem_rd_req = rd; mem_wr_req = wr;
    for (int c = 1; c <= 20 && rdy_cyc == 0; c++) begin
      @(negedge Clk);
      if (!mem_ce_n) ce_cnt++;
      if (!mem_oe_n) oe_cnt++;
      if (!mem_we_n) we_cnt++;
      if (!mem_ce_n && mem_addr !== exp_addr) stable = 1'b0;
      if (!mem_we_n && mem_wdata !== exp_wdata) stable = 1'b0;
      if (mem_rdy === 1'b1) rdy_cyc = c;
      mem_rd_req = 1'b0; mem_wr_req = 1'b0; LD_MAR = 1'b0; LD_MDR = 1'b0; MIO_EN = 1'b0;
      if (poke && c == 1) begin
        LD_MAR = 1'b1; LD_MDR = 1'b1; bus_in = 16'hFFFF;
      end
    end
    chk({tag, "_rdy_latency"}, rdy_cyc, W + 1);
    chk({tag, "_ce_cycles"}, ce_cnt, strobes_on ? W : 0);
    chk({tag, "_oe_cycles"}, oe_cnt, (strobes_on && rd) ? W : 0);
    chk({tag, "_we_cycles"}, we_cnt, (strobes_on && !rd && wr) ? W : 0);
    chk({tag, "_addr_data_stable"}, stable, 1'b1);
    if (rd) begin
      if (exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        chk({tag, "_mdr"}, MDR, exp_d);
      end else begin
        chk({tag, "_queue_empty"}, 1'b1, 1'b0);
      end
    end
    @(negedge Clk);
    chk({tag, "_rdy_pulse_end"}, mem_rdy, 1'b0);
    chk({tag, "_idle_after"}, busy, 1'b0);
  endtask

  initial begin
    int rdy_seen;
    n_tests = 0; n_fail = 0;
    Reset = 1'b1; bus_in = 16'h0; LD_MAR = 1'b0; LD_MDR = 1'b0; MIO_EN = 1'b0;
    mem_rd_req = 1'b0; mem_wr_req = 1'b0; mem_rdata = 16'h0;
`ifdef MMIO_LED_EN
    SW = 12'h000;
`endif

    // Reset values.
    repeat (2) @(negedge Clk);
    chk("rst_mar", MAR, 16'h0000);
    chk("rst_mdr", MDR, 16'h0000);
    chk("rst_ce", mem_ce_n, 1'b1);
    chk("rst_oe", mem_oe_n, 1'b1);
    chk("rst_we", mem_we_n, 1'b1);
    chk("rst_rdy", mem_rdy, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", state_dbg, 2'd0);
`ifdef MMIO_LED_EN
    chk("rst_led", LED, 12'h000);
`endif
    Reset = 1'b0;
    @(negedge Clk);

    // Plain read of 3000.
    load_mar(16'h3000);
    chk("mar_load", MAR, 16'h3000);
    mem_rdata = 16'hABCD;
    exp_q.push_back(16'hABCD);
    run_access("rd3000", 1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, 1'b1);

    // Write 1234 to 4001.
    load_mar(16'h4001);
    load_mdr(16'h1234, 1'b0);
    chk("mdr_load", MDR, 16'h1234);
    run_access("wr4001", 1'b0, 1'b1, 16'h4001, 16'h1234, 1'b0, 1'b1);
    chk("wr_mdr_kept", MDR, 16'h1234);

    // LD_MDR with the memory path selected does not touch MDR.
    load_mdr(16'h7777, 1'b1);
    chk("mio_ld_ignored", MDR, 16'h1234);

    // Both requests: read wins; loads while busy are ignored.
    load_mar(16'h5000);
    mem_rdata = 16'h5A5A;
    exp_q.push_back(16'h5A5A);
    run_access("both", 1'b1, 1'b1, 16'h5000, 16'h1234, 1'b1, 1'b1);
    chk("busy_ld_mar", MAR, 16'h5000);

    // Load and request in the same cycle, back-to-back with the previous access.
    LD_MAR = 1'b1; bus_in = 16'h6000;
    mem_rdata = 16'h0F0F;
    exp_q.push_back(16'h0F0F);
    run_access("same_cyc", 1'b1, 1'b0, 16'h6000, 16'h5A5A, 1'b0, 1'b1);
    chk("same_cyc_mar", MAR, 16'h6000);

`ifdef MMIO_LED_EN
    // I/O write and read at FFFF: no SRAM strobes.
    load_mar(16'hFFFF);
    load_mdr(16'h0A5C, 1'b0);
    run_access("mmio_wr", 1'b0, 1'b1, 16'hFFFF, 16'h0A5C, 1'b0, 1'b0);
    chk("mmio_led", LED, 12'hA5C);
    SW = 12'h123;
    mem_rdata = 16'hDEAD;
    exp_q.push_back(16'h0123);
    run_access("mmio_rd", 1'b1, 1'b0, 16'hFFFF, 16'h0A5C, 1'b0, 1'b0);
`else
    // FFFF is ordinary SRAM in this build.
    load_mar(16'hFFFF);
    mem_rdata = 16'hC0DE;
    exp_q.push_back(16'hC0DE);
    run_access("ffff_rd", 1'b1, 1'b0, 16'hFFFF, 16'h0F0F, 1'b0, 1'b1);
`endif

    // Reset in the second RD cycle aborts the read.
    load_mar(16'h2000);
    mem_rdata = 16'hBEEF;
    mem_rd_req = 1'b1;
    @(negedge Clk);
    mem_rd_req = 1'b0;
    chk("abort_busy_rd1", busy, 1'b1);
    @(negedge Clk);
    chk("abort_oe_rd2", mem_oe_n, 1'b0);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort_ce", mem_ce_n, 1'b1);
    chk("abort_oe", mem_oe_n, 1'b1);
    chk("abort_mdr", MDR, 16'h0000);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rdy", mem_rdy, 1'b0);
    rdy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (mem_rdy === 1'b1) rdy_seen++;
    end
    chk("abort_no_rdy", rdy_seen, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the LC-3 bus mux.
- Captures the shared 16-bit bus into MAR/MDR and runs single-word SRAM reads and writes with a fixed wait-state count.
- Drives MDR back toward the bus mux (MDR gate input) and signals completion to the ISDU control FSM via mem_rdy.

Parameters:
WAIT_CYCLES, 2, SRAM access cycles per read/write, legal range 1..15
ADDR_W, 16, address width of MAR and mem_addr

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
bus_in  input  16  shared datapath bus (bus mux output)
LD_MAR  input  1  load MAR from bus_in
LD_MDR  input  1  load MDR (source selected by MIO_EN)
MIO_EN  input  1  1 = memory path owns MDR; 0 = bus_in loads MDR
mem_rd_req  input  1  start read of M[MAR]; sampled in IDLE only
mem_wr_req  input  1  start write of MDR to M[MAR]; sampled in IDLE only
mem_rdata  input  16  SRAM read data
MAR  output  ADDR_W  memory address register
MDR  output  16  memory data register, feeds bus mux
mem_addr  output  ADDR_W  SRAM address, equals MAR
mem_wdata  output  16  SRAM write data, equals MDR
mem_ce_n  output  1  SRAM chip enable, active low
mem_oe_n  output  1  SRAM output enable, active low
mem_we_n  output  1  SRAM write enable, active low
mem_rdy  output  1  one-cycle completion pulse
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - MAR=0, MDR=0, state=IDLE, counter=0.
  - mem_rdy=0, busy=0.
  - ce_n/oe_n/we_n=1.
- Reset in any state aborts the access. Strobes are deasserted and MDR cleared at that edge. No mem_rdy is issued.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - LD_MAR: MAR<=bus_in.
  - LD_MDR with MIO_EN=0: MDR<=bus_in.
  - LD_MDR with MIO_EN=1: ignored; MDR is loaded only by read completion.
  - mem_rd_req -> RD. Else mem_wr_req -> WR.
  - Both requests asserted together: read wins; write is dropped, not queued.
  - Requests and loads in the same cycle: MAR/MDR update and the request is accepted. The access uses the values present after that edge.
- RD:
  - ce_n=0, oe_n=0, we_n=1 for exactly WAIT_CYCLES cycles; counter counts up from 0.
  - At the edge ending the final cycle: MDR<=mem_rdata, go to DONE.
- WR:
  - ce_n=0, we_n=0, oe_n=1 for exactly WAIT_CYCLES cycles.
  - mem_addr and mem_wdata are held stable for the entire window. Then go to DONE.
- DONE: mem_rdy=1 for one cycle, strobes inactive, then IDLE.
- While busy: LD_MAR, LD_MDR, mem_rd_req and mem_wr_req are ignored, so address and data cannot change mid-access.
- Latency: request sampled at edge N; mem_rdy high in cycle N+WAIT_CYCLES+1. Read data is visible on MDR in that same cycle.
- Back-to-back accesses: the next request is accepted in the IDLE cycle after DONE. Minimum period is WAIT_CYCLES+2 cycles.
- Counter width is 4 bits. It wraps to 0 on every state exit and never free-runs.
- All outputs are registered except mem_addr/mem_wdata, which are direct copies of MAR/MDR.

Optional Feature:
- Macro: MMIO_LED_EN.
- When defined:
  - Adds ports SW input 12 and LED output 12; LED resets to 0.
  - Address 16'hFFFF is memory-mapped I/O.
  - Write to FFFF: LED<=MDR[11:0]; SRAM strobes stay inactive.
  - Read from FFFF: MDR<={4'b0,SW}; SRAM strobes stay inactive.
  - Timing and mem_rdy latency are identical to a normal access.
- When undefined: FFFF is ordinary SRAM, and the SW and LED ports do not exist.

Test Plan:
- Reset mid-RD (WAIT_CYCLES=2, Reset asserted in second RD cycle) -> next cycle ce_n=oe_n=1, MDR=0000, busy=0, no mem_rdy pulse.
- LD_MAR with bus_in=3000, then mem_rd_req, mem_rdata=ABCD -> ce_n/oe_n low for 2 cycles, mem_addr=3000; MDR=ABCD and mem_rdy=1 exactly 3 cycles after request.
- LD_MAR bus_in=4001, LD_MDR MIO_EN=0 bus_in=1234, then mem_wr_req -> we_n low 2 cycles with mem_addr=4001, mem_wdata=1234; oe_n stays 1; mem_rdy pulses once.
- mem_rd_req and mem_wr_req in the same cycle -> only a read occurs; we_n never low. LD_MAR bus_in=FFFF while busy -> MAR unchanged.
- (MMIO_LED_EN) MAR=FFFF, MDR=0A5C, write -> LED=A5C, ce_n never low. Then SW=123, read -> MDR=0123.
